// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - memory request/acknowledge bundle for the multicycle controller
interface multicycle_control_if;
  logic mem_req;
  logic mem_read;
  logic mem_write;
  logic iord;
  logic mem_ack;

  modport master (
    output mem_req, mem_read, mem_write, iord,
    input  mem_ack
  );

  modport slave (
    input  mem_req, mem_read, mem_write, iord,
    output mem_ack
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM with memory wait timeout and sticky traps
module multicycle_control #(
  parameter int WAIT_MAX   = 15,
  parameter bit ENABLE_BGT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  multicycle_control_if.master mem,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 reg_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 alu_src_a,
  output logic                 sign_zero,
  output logic                 branch_src,
  output logic [2:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           pc_source,
  output logic                 retire,
  output logic                 illegal,
  output logic                 bus_error,
  output logic [3:0]           state
);
  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGT   = 6'b000101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC_R = 4'd7,
    S_EXEC_I = 4'd8,
    S_ALUWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_error_q, bus_error_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Counter is zero in every non-memory state, so each memory state is entered with a clean count.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    illegal_d   = illegal_q;
    bus_error_d = bus_error_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (mem.mem_ack) begin
          if (state_q == S_FETCH)      state_d = S_DECODE;
          else if (state_q == S_MEMRD) state_d = S_MEMWB;
          else                         state_d = S_FETCH;
        end else if (cnt_q == CNT_LAST) begin
          bus_error_d = 1'b1;
          state_d     = S_TRAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_BEQ:       state_d = S_BRANCH;
          OP_BGT: begin
            if (ENABLE_BGT) begin
              state_d = S_BRANCH;
            end else begin
              state_d   = S_TRAP;
              illegal_d = 1'b1;
            end
          end
          OP_XORI:      state_d = S_EXEC_I;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_EXEC_R, S_EXEC_I: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    mem.iord      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    sign_zero     = 1'b0;
    branch_src    = 1'b0;
    alu_src_b     = 3'b000;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    retire        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem.mem_req  = 1'b1;
        mem.mem_read = 1'b1;
        if (mem.mem_ack) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 3'b001;
        end
      end
      S_DECODE: alu_src_b = 3'b011;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 3'b010;
      end
      S_MEMRD: begin
        mem.mem_req  = 1'b1;
        mem.mem_read = 1'b1;
        mem.iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem.mem_req   = 1'b1;
        mem.mem_write = 1'b1;
        mem.iord      = 1'b1;
        retire        = mem.mem_ack;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        // sll/srl take their second operand from the shift-amount field
        alu_src_b = (funct == 6'h00 || funct == 6'h02) ? 3'b100 : 3'b000;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 3'b010;
        alu_op    = 2'b11;
        sign_zero = 1'b1;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = (opcode == OP_RTYPE);
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_src    = (opcode == OP_BGT);
        retire        = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
      end
      default: ;
    endcase
  end

  assign state     = state_q;
  assign illegal   = illegal_q;
  assign bus_error = bus_error_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed bench for multicycle_control, two parameter sets against a behavioural model
module tb_multicycle_control;
  localparam logic [5:0] RT = 6'b000000, J = 6'b000010, BEQ = 6'b000100, BGT = 6'b000101;
  localparam logic [5:0] XORI = 6'b001110, LW = 6'b100011, SW = 6'b101011, ILL = 6'b111111;

  logic clk, rst, ack;
  logic [5:0] opcode, funct;
  int n_cmp = 0, n_bad = 0;

  multicycle_control_if bus0 ();
  multicycle_control_if bus1 ();
  assign bus0.mem_ack = ack;
  assign bus1.mem_ack = ack;

  logic irw0, pcw0, pcc0, rw0, rdst0, m2r0, asa0, sz0, bsrc0, ret0, ill0, be0;
  logic irw1, pcw1, pcc1, rw1, rdst1, m2r1, asa1, sz1, bsrc1, ret1, ill1, be1;
  logic [2:0] asb0, asb1;
  logic [1:0] aop0, aop1, pcs0, pcs1;
  logic [3:0] st0, st1;

  multicycle_control #(.WAIT_MAX(3), .ENABLE_BGT(1'b1)) dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem(bus0),
    .ir_write(irw0), .pc_write(pcw0), .pc_write_cond(pcc0), .reg_write(rw0),
    .reg_dst(rdst0), .mem_to_reg(m2r0), .alu_src_a(asa0), .sign_zero(sz0),
    .branch_src(bsrc0), .alu_src_b(asb0), .alu_op(aop0), .pc_source(pcs0),
    .retire(ret0), .illegal(ill0), .bus_error(be0), .state(st0)
  );

  multicycle_control #(.WAIT_MAX(15), .ENABLE_BGT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem(bus1),
    .ir_write(irw1), .pc_write(pcw1), .pc_write_cond(pcc1), .reg_write(rw1),
    .reg_dst(rdst1), .mem_to_reg(m2r1), .alu_src_a(asa1), .sign_zero(sz1),
    .branch_src(bsrc1), .alu_src_b(asb1), .alu_op(aop1), .pc_source(pcs1),
    .retire(ret1), .illegal(ill1), .bus_error(be1), .state(st1)
  );

  wire [20:0] act0 = {bus0.mem_req, bus0.mem_read, bus0.mem_write, bus0.iord, irw0, pcw0, pcc0,
                      rw0, rdst0, m2r0, asa0, sz0, bsrc0, asb0, aop0, pcs0, ret0};
  wire [20:0] act1 = {bus1.mem_req, bus1.mem_read, bus1.mem_write, bus1.iord, irw1, pcw1, pcc1,
                      rw1, rdst1, m2r1, asa1, sz1, bsrc1, asb1, aop1, pcs1, ret1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[dut%0d] actual=%0h required=%0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Expected control word for a state, written straight from the per-state output table.
  function automatic logic [20:0] exp_out(input int s, input bit a, input logic [5:0] op, input logic [5:0] fn);
    bit req = 0, rd = 0, wr = 0, io = 0, irw = 0, pcw = 0, pcc = 0, rw = 0, rdst = 0;
    bit m2r = 0, asa = 0, sz = 0, bsrc = 0, ret = 0;
    bit [2:0] asb = 0;
    bit [1:0] aop = 0, pcs = 0;
    case (s)
      1:  begin req = 1; rd = 1; if (a) begin irw = 1; pcw = 1; asb = 3'b001; end end
      2:  asb = 3'b011;
      3:  begin asa = 1; asb = 3'b010; end
      4:  begin req = 1; rd = 1; io = 1; end
      5:  begin rw = 1; m2r = 1; ret = 1; end
      6:  begin req = 1; wr = 1; io = 1; ret = a; end
      7:  begin asa = 1; aop = 2'b10; asb = (fn == 6'h00 || fn == 6'h02) ? 3'b100 : 3'b000; end
      8:  begin asa = 1; asb = 3'b010; aop = 2'b11; sz = 1; end
      9:  begin rw = 1; rdst = (op == RT); ret = 1; end
      10: begin asa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; bsrc = (op == BGT); ret = 1; end
      11: begin pcw = 1; pcs = 2'b10; ret = 1; end
      default: ;
    endcase
    return {req, rd, wr, io, irw, pcw, pcc, rw, rdst, m2r, asa, sz, bsrc, asb, aop, pcs, ret};
  endfunction

  int ms[2], mcnt[2];
  bit mill[2], mbe[2];
  bit m_valid = 0;
  int wm[2] = '{3, 15};
  bit bg[2] = '{1'b1, 1'b0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ms[i] = 0; mcnt[i] = 0; mill[i] = 0; mbe[i] = 0;
      end else begin
        case (ms[i])
          0: ms[i] = 1;
          1, 4, 6: begin
            if (ack) begin
              mcnt[i] = 0;
              ms[i] = (ms[i] == 1) ? 2 : (ms[i] == 4) ? 5 : 1;
            end else begin
              mcnt[i] = mcnt[i] + 1;
              if (mcnt[i] >= wm[i]) begin mbe[i] = 1; ms[i] = 12; mcnt[i] = 0; end
            end
          end
          2: begin
            if (opcode == LW || opcode == SW)      ms[i] = 3;
            else if (opcode == RT)                 ms[i] = 7;
            else if (opcode == BEQ)                ms[i] = 10;
            else if (opcode == BGT && bg[i])       ms[i] = 10;
            else if (opcode == XORI)               ms[i] = 8;
            else if (opcode == J)                  ms[i] = 11;
            else begin ms[i] = 12; mill[i] = 1; end
          end
          3: ms[i] = (opcode == LW) ? 4 : 6;
          7, 8: ms[i] = 9;
          12: ;
          default: ms[i] = 1;
        endcase
      end
    end
    if (rst) m_valid = 1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      cmp("state", 0, 32'(st0), 32'(ms[0]));
      cmp("illegal", 0, 32'(ill0), 32'(mill[0]));
      cmp("bus_error", 0, 32'(be0), 32'(mbe[0]));
      cmp("ctrl", 0, 32'(act0), 32'(exp_out(ms[0], ack, opcode, funct)));
      cmp("state", 1, 32'(st1), 32'(ms[1]));
      cmp("illegal", 1, 32'(ill1), 32'(mill[1]));
      cmp("bus_error", 1, 32'(be1), 32'(mbe[1]));
      cmp("ctrl", 1, 32'(act1), 32'(exp_out(ms[1], ack, opcode, funct)));
    end
  end

  task automatic step(input bit r, input bit a, input logic [5:0] op, input logic [5:0] fn, input int s0);
    @(posedge clk);
    #1;
    rst = r; ack = a; opcode = op; funct = fn;
    @(negedge clk);
    cmp("lit_state", 0, 32'(st0), 32'(s0));
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0; opcode = 6'd0; funct = 6'd0;
    repeat (2) @(posedge clk);
    step(0, 0, LW, 0, 0);
    cmp("lit_rst_state", 1, 32'(st1), 0);
    cmp("lit_rst_flags", 0, 32'({ill0, be0}), 0);
    step(0, 0, LW, 0, 1);
    step(0, 1, LW, 0, 1);  cmp("lit_ir_write", 0, 32'(irw0), 1);
    step(0, 0, LW, 0, 2);
    step(0, 0, LW, 0, 3);
    step(0, 0, LW, 0, 4);
    step(0, 1, LW, 0, 4);
    step(0, 0, LW, 0, 5);  cmp("lit_lw_wb", 0, 32'({ret0, rw0, m2r0}), 32'h7);
    step(0, 1, RT, 6'h02, 1);
    step(0, 0, RT, 6'h02, 2);
    step(0, 0, RT, 6'h02, 7);  cmp("lit_shamt_src", 0, 32'(asb0), 32'h4);
    step(0, 0, RT, 6'h02, 9);  cmp("lit_reg_dst_r", 0, 32'(rdst0), 1);
    step(0, 1, RT, 6'h20, 1);
    step(0, 0, RT, 6'h20, 2);
    step(0, 0, RT, 6'h20, 7);  cmp("lit_regb_src", 0, 32'(asb0), 0);
    step(0, 0, RT, 6'h20, 9);
    step(0, 1, SW, 0, 1);
    step(0, 0, SW, 0, 2);
    step(0, 0, SW, 0, 3);
    step(0, 0, SW, 0, 6);
    step(0, 0, SW, 0, 6);
    step(0, 0, SW, 0, 6);
    step(0, 1, SW, 0, 12); cmp("lit_bus_error", 0, 32'(be0), 1); cmp("lit_still_wr", 1, 32'(st1), 6);
    step(0, 0, SW, 0, 12); cmp("lit_slow_acked", 1, 32'(st1), 1);
    step(1, 0, SW, 0, 12);
    step(0, 0, SW, 0, 0);  cmp("lit_be_cleared", 0, 32'(be0), 0);
    step(0, 1, SW, 0, 1);
    step(0, 0, SW, 0, 2);
    step(0, 0, SW, 0, 3);
    step(0, 0, SW, 0, 6);
    step(0, 0, SW, 0, 6);
    step(0, 1, SW, 0, 6);  cmp("lit_sw_retire", 0, 32'(ret0), 1);
    step(0, 1, BGT, 0, 1); cmp("lit_ack_wins", 0, 32'(be0), 0);
    step(0, 0, BGT, 0, 2);
    step(0, 0, BGT, 0, 10);
    cmp("lit_bgt_ctrl", 0, 32'({bsrc0, pcc0}), 32'h3);
    cmp("lit_bgt_off", 1, 32'({st1, ill1}), 32'({4'd12, 1'b1}));
    step(0, 1, ILL, 0, 1);
    step(0, 0, ILL, 0, 2);
    step(0, 0, ILL, 0, 12);
    for (int i = 0; i < 20; i++) begin
      step(0, i[0], ILL, 0, 12);
      cmp("lit_illegal_held", 0, 32'(ill0), 1);
    end
    step(1, 0, LW, 0, 12);
    step(0, 0, LW, 0, 0);  cmp("lit_ill_cleared", 0, 32'(ill0), 0);
    step(0, 0, LW, 0, 1);
    step(0, 1, LW, 0, 1);
    step(0, 0, LW, 0, 2);
    step(0, 0, LW, 0, 3);
    step(0, 0, LW, 0, 4);
    step(1, 1, LW, 0, 4);
    step(0, 0, LW, 0, 0);  cmp("lit_rst_outputs", 0, 32'(act0), 0);
    step(0, 1, XORI, 0, 1);
    step(0, 0, XORI, 0, 2);
    step(0, 0, XORI, 0, 8);
    step(0, 0, XORI, 0, 9); cmp("lit_reg_dst_i", 0, 32'(rdst0), 0);
    step(0, 1, J, 0, 1);
    step(0, 0, J, 0, 2);
    step(0, 0, J, 0, 11);
    step(0, 1, BEQ, 0, 1);
    step(0, 0, BEQ, 0, 2);
    step(0, 0, BEQ, 0, 10); cmp("lit_beq_src", 0, 32'(bsrc0), 0);
    step(0, 0, BEQ, 0, 1);
    step(0, 0, BEQ, 0, 1);
    step(0, 0, BEQ, 0, 1);
    step(0, 0, BEQ, 0, 12); cmp("lit_fetch_timeout", 0, 32'(be0), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
